// File: rtl/uart_pkg.sv
// Shared UART defaults: baud generator widths, oversample rate and a divisor record.
package uart_pkg;
  localparam int UART_DIV_W   = 16;
  localparam int UART_FRAC_W  = 4;
  localparam int UART_OS_RATE = 16;

  typedef struct packed {
    logic [UART_DIV_W-1:0]  div_int;
    logic [UART_FRAC_W-1:0] div_frac;
  } baud_div_t;

  // 100 MHz / (16 * 115200) = 54.25 -> 54 + 4/16
  localparam baud_div_t DIV_115200_100MHZ = '{div_int: 16'd54, div_frac: 4'd4};
endpackage

// File: rtl/uart_frac_accum.sv
// Fractional phase accumulator: adds the active fraction once per oversample period
// and reports the carry that stretches the current period by one cycle.
module uart_frac_accum #(
  parameter int FRAC_W = 4
) (
  input  logic              Clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              step,
  input  logic [FRAC_W-1:0] frac_in,
  output logic              carry
);
  logic [FRAC_W-1:0] frac_acc;
  logic [FRAC_W:0]   sum;

  assign sum   = {1'b0, frac_acc} + {1'b0, frac_in};
  assign carry = sum[FRAC_W];

  always_ff @(posedge Clk or posedge reset) begin
    if (reset) begin
      frac_acc <= '0;
    end else if (clear) begin
      frac_acc <= '0;
    end else if (step) begin
      frac_acc <= sum[FRAC_W-1:0];
    end
  end
endmodule

// File: rtl/uart_frac_baud_gen.sv
// Fractional baud-rate generator: oversample strobe, bit strobe and 50% baud square wave,
// with a shadowed divisor that only switches at an oversample boundary.
module uart_frac_baud_gen
  import uart_pkg::*;
#(
  parameter int DIV_W   = UART_DIV_W,
  parameter int FRAC_W  = UART_FRAC_W,
  parameter int OS_RATE = UART_OS_RATE
) (
  input  logic              Clk,
  input  logic              reset,
  input  logic              enable,
  input  logic [DIV_W-1:0]  div_int,
  input  logic [FRAC_W-1:0] div_frac,
  input  logic              div_load,
  output logic              tick_os,
  output logic              tick_baud,
  output logic              baud_out,
  output logic              cfg_err
);
  localparam int OS_W = (OS_RATE > 2) ? $clog2(OS_RATE) : 1;
  localparam logic [OS_W-1:0] OS_LAST = OS_W'(OS_RATE - 1);
  localparam logic [OS_W-1:0] OS_HALF = OS_W'(OS_RATE / 2 - 1);

  logic [DIV_W-1:0]  shadow_int, active_int;
  logic [FRAC_W-1:0] shadow_frac, active_frac;
  logic [DIV_W:0]    cnt, last_cnt;
  logic [OS_W-1:0]   os_cnt;
  logic              carry, stalled, wrap;

  assign stalled  = (active_int == '0);
  assign cfg_err  = stalled;
  // Period is active_int + carry cycles, so its last count is active_int - 1 + carry.
  assign last_cnt = {1'b0, active_int} - {{DIV_W{1'b0}}, ~carry};
  assign wrap     = enable && !stalled && (cnt == last_cnt);

  uart_frac_accum #(.FRAC_W(FRAC_W)) u_accum (
    .Clk     (Clk),
    .reset   (reset),
    .clear   (!enable),
    .step    (wrap),
    .frac_in (active_frac),
    .carry   (carry)
  );

  always_ff @(posedge Clk or posedge reset) begin
    if (reset) begin
      shadow_int  <= DIV_W'(1);
      shadow_frac <= '0;
    end else if (div_load) begin
      shadow_int  <= div_int;
      shadow_frac <= div_frac;
    end
  end

  // Idle or stalled generators have no tick pending, so a load may go straight to active.
  always_ff @(posedge Clk or posedge reset) begin
    if (reset) begin
      active_int  <= DIV_W'(1);
      active_frac <= '0;
    end else if (!enable || stalled) begin
      active_int  <= div_load ? div_int  : shadow_int;
      active_frac <= div_load ? div_frac : shadow_frac;
    end else if (wrap) begin
      active_int  <= shadow_int;
      active_frac <= shadow_frac;
    end
  end

  always_ff @(posedge Clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (!enable || wrap) begin
      cnt <= '0;
    end else if (!stalled) begin
      cnt <= cnt + (DIV_W+1)'(1);
    end
  end

  always_ff @(posedge Clk or posedge reset) begin
    if (reset) begin
      os_cnt    <= '0;
      tick_os   <= 1'b0;
      tick_baud <= 1'b0;
      baud_out  <= 1'b0;
    end else if (!enable) begin
      os_cnt    <= '0;
      tick_os   <= 1'b0;
      tick_baud <= 1'b0;
      baud_out  <= 1'b0;
    end else begin
      tick_os   <= wrap;
      tick_baud <= wrap && (os_cnt == OS_LAST);
      if (wrap) begin
        os_cnt <= (os_cnt == OS_LAST) ? '0 : os_cnt + OS_W'(1);
        if (os_cnt == OS_LAST || os_cnt == OS_HALF) begin
          baud_out <= ~baud_out;
        end
      end
    end
  end
endmodule

// File: tb/tb_uart_frac_baud_gen.sv
// Bench for uart_frac_baud_gen: tick timing derived from ideal tick instants k*int + floor(k*frac/2^F).
module tb_uart_frac_baud_gen;
  import uart_pkg::*;

  localparam int FDEN = 1 << UART_FRAC_W;
  localparam int OSR  = UART_OS_RATE;

  logic                   Clk = 1'b0;
  logic                   reset, enable, div_load;
  logic [UART_DIV_W-1:0]  div_int;
  logic [UART_FRAC_W-1:0] div_frac;
  logic                   tick_os, tick_baud, baud_out, cfg_err;

  int n_cmp = 0;
  int n_err = 0;

  always #5 Clk = ~Clk;

  uart_frac_baud_gen dut (
    .Clk       (Clk),
    .reset     (reset),
    .enable    (enable),
    .div_int   (div_int),
    .div_frac  (div_frac),
    .div_load  (div_load),
    .tick_os   (tick_os),
    .tick_baud (tick_baud),
    .baud_out  (baud_out),
    .cfg_err   (cfg_err)
  );

  // Expected {tick_os, tick_baud, baud_out} c cycles after enable rose with divisor i + f/FDEN.
  function automatic logic [2:0] model(input int i, input int f, input int c);
    int  n;
    logic tk;
    n = 0;
    while (((n + 1) * i + ((n + 1) * f) / FDEN) <= c) n++;
    tk = (n > 0) && ((n * i + (n * f) / FDEN) == c);
    return {tk, tk && (n % OSR == 0), ((n / (OSR / 2)) % 2) == 1};
  endfunction

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic load_disabled(input int i, input int f);
    enable   = 1'b0;
    div_load = 1'b0;
    step();
    div_int  = UART_DIV_W'(i);
    div_frac = UART_FRAC_W'(f);
    div_load = 1'b1;
    step();
    div_load = 1'b0;
    enable   = 1'b1;
  endtask

  task automatic test_reset();
    logic [3:0] got;
    logic [2:0] exp, g3;
    reset = 1'b1; enable = 1'b0; div_load = 1'b0; div_int = '0; div_frac = '0;
    repeat (3) step();
    got = {tick_os, tick_baud, baud_out, cfg_err};
    n_cmp++;
    if (got !== 4'b0000) begin
      n_err++;
      $display("FAIL reset_outputs got=%b exp=0000", got);
    end
    reset  = 1'b0;
    enable = 1'b1;
    for (int c = 1; c <= 20; c++) begin
      step();
      g3  = {tick_os, tick_baud, baud_out};
      exp = model(1, 0, c);
      n_cmp++;
      if (g3 !== exp || cfg_err !== 1'b0) begin
        n_err++;
        $display("FAIL reset_default_div c=%0d got=%b/%b exp=%b/0", c, g3, cfg_err, exp);
      end
    end
  endtask

  task automatic test_div5();
    logic [2:0] got, exp;
    load_disabled(5, 0);
    for (int c = 1; c <= 200; c++) begin
      step();
      got = {tick_os, tick_baud, baud_out};
      exp = model(5, 0, c);
      n_cmp++;
      if (got !== exp) begin
        n_err++;
        $display("FAIL div5 c=%0d got=%b exp=%b", c, got, exp);
      end
    end
  endtask

  task automatic test_div_frac();
    logic [2:0] got, exp;
    int i, f;
    i = int'(DIV_115200_100MHZ.div_int);
    f = int'(DIV_115200_100MHZ.div_frac);
    load_disabled(i, f);
    for (int c = 1; c <= 1000; c++) begin
      step();
      got = {tick_os, tick_baud, baud_out};
      exp = model(i, f, c);
      n_cmp++;
      if (got !== exp) begin
        n_err++;
        $display("FAIL div_54_25 c=%0d got=%b exp=%b", c, got, exp);
      end
    end
  endtask

  task automatic test_div1();
    logic [2:0] got, exp;
    load_disabled(1, 0);
    for (int c = 1; c <= 100; c++) begin
      step();
      got = {tick_os, tick_baud, baud_out};
      exp = model(1, 0, c);
      n_cmp++;
      if (got !== exp || cfg_err !== 1'b0) begin
        n_err++;
        $display("FAIL div1 c=%0d got=%b/%b exp=%b/0", c, got, cfg_err, exp);
      end
    end
  endtask

  task automatic test_random();
    logic [2:0] got, exp;
    int i, f;
    for (int r = 0; r < 6; r++) begin
      i = int'($urandom_range(1, 20));
      f = int'($urandom_range(0, FDEN - 1));
      load_disabled(i, f);
      for (int c = 1; c <= 400; c++) begin
        step();
        got = {tick_os, tick_baud, baud_out};
        exp = model(i, f, c);
        n_cmp++;
        if (got !== exp) begin
          n_err++;
          $display("FAIL random_div_%0d_%0d c=%0d got=%b exp=%b", i, f, c, got, exp);
        end
      end
    end
  endtask

  task automatic test_midload();
    int  ticks [8] = '{10, 30, 50, 70, 75, 80, 85, 90};
    logic exp;
    load_disabled(10, 0);
    for (int c = 1; c <= 90; c++) begin
      div_load = 1'b0;
      if (c == 5) begin
        div_int = UART_DIV_W'(20); div_frac = '0; div_load = 1'b1;
      end
      if (c == 50) begin
        div_int = UART_DIV_W'(5); div_frac = '0; div_load = 1'b1;
      end
      step();
      exp = 1'b0;
      foreach (ticks[k]) if (ticks[k] == c) exp = 1'b1;
      n_cmp++;
      if (tick_os !== exp) begin
        n_err++;
        $display("FAIL midload c=%0d got=%b exp=%b", c, tick_os, exp);
      end
    end
    div_load = 1'b0;
  endtask

  task automatic test_cfg_err();
    logic et, ee;
    load_disabled(3, 0);
    for (int c = 1; c <= 10; c++) begin
      div_load = (c == 4);
      if (c == 4) begin
        div_int = '0; div_frac = '0;
      end
      step();
      et = (c == 3 || c == 6);
      ee = (c >= 6);
      n_cmp++;
      if (tick_os !== et || cfg_err !== ee) begin
        n_err++;
        $display("FAIL cfg_err_entry c=%0d got=%b%b exp=%b%b", c, tick_os, cfg_err, et, ee);
      end
    end
    div_load = 1'b0;
    for (int c = 0; c < 200; c++) begin
      step();
      n_cmp++;
      if ({tick_os, tick_baud, baud_out, cfg_err} !== 4'b0001) begin
        n_err++;
        $display("FAIL cfg_err_stall c=%0d got=%b exp=0001", c,
                 {tick_os, tick_baud, baud_out, cfg_err});
      end
    end
    div_int = UART_DIV_W'(8); div_frac = '0; div_load = 1'b1;
    step();
    div_load = 1'b0;
    n_cmp++;
    if (cfg_err !== 1'b0) begin
      n_err++;
      $display("FAIL cfg_err_recover got=%b exp=0", cfg_err);
    end
    for (int c = 1; c <= 9; c++) begin
      step();
      n_cmp++;
      if (tick_os !== (c == 8)) begin
        n_err++;
        $display("FAIL cfg_err_first_tick c=%0d got=%b exp=%b", c, tick_os, (c == 8));
      end
    end
  endtask

  task automatic test_enable_reset();
    logic [2:0] got, exp;
    load_disabled(3, 0);
    for (int c = 1; c <= 30; c++) begin
      step();
      got = {tick_os, tick_baud, baud_out};
      exp = model(3, 0, c);
      n_cmp++;
      if (got !== exp) begin
        n_err++;
        $display("FAIL pre_disable c=%0d got=%b exp=%b", c, got, exp);
      end
    end
    enable = 1'b0;
    step();
    n_cmp++;
    if ({tick_os, tick_baud, baud_out} !== 3'b000) begin
      n_err++;
      $display("FAIL disable_clear got=%b exp=000", {tick_os, tick_baud, baud_out});
    end
    enable = 1'b1;
    for (int c = 1; c <= 12; c++) begin
      step();
      got = {tick_os, tick_baud, baud_out};
      exp = model(3, 0, c);
      n_cmp++;
      if (got !== exp) begin
        n_err++;
        $display("FAIL reenable c=%0d got=%b exp=%b", c, got, exp);
      end
    end
    reset = 1'b1;
    #1;
    n_cmp++;
    if ({tick_os, tick_baud, baud_out, cfg_err} !== 4'b0000) begin
      n_err++;
      $display("FAIL async_reset got=%b exp=0000", {tick_os, tick_baud, baud_out, cfg_err});
    end
    step();
    reset = 1'b0;
    for (int c = 1; c <= 10; c++) begin
      step();
      got = {tick_os, tick_baud, baud_out};
      exp = model(1, 0, c);
      n_cmp++;
      if (got !== exp) begin
        n_err++;
        $display("FAIL post_reset_shadow c=%0d got=%b exp=%b", c, got, exp);
      end
    end
  endtask

  initial begin
    test_reset();
    test_div5();
    test_div_frac();
    test_div1();
    test_random();
    test_midload();
    test_cfg_err();
    test_enable_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
